l2_writeback_buffer: RTL and testbench



---
 rtl/l2_writeback_buffer_if.sv | 53 +++++
 rtl/l2_writeback_buffer.sv | 196 +++++++++++++++++++
 tb/tb_l2_writeback_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_writeback_buffer_if.sv
// AXI-style bus bundle shared by the upstream (L2-facing) and downstream
// (interconnect-facing) sides of the write-back buffer.
interface l2_writeback_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 3
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [7:0]              aw_len;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [7:0]              ar_len;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ID_WIDTH-1:0]     r_id;
  logic [1:0]              r_resp;
  logic                    r_last;

  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, input aw_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input b_valid, b_id, b_resp, output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len, input ar_ready,
    input r_valid, r_data, r_id, r_resp, r_last, output r_ready
  );

  modport slave (
    input aw_valid, aw_addr, aw_id, aw_len, output aw_ready,
    input w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_id, b_resp, input b_ready,
    input ar_valid, ar_addr, ar_id, ar_len, output ar_ready,
    output r_valid, r_data, r_id, r_resp, r_last, input r_ready
  );
endinterface

// File: rtl/l2_writeback_buffer.sv
// L2 eviction write-back buffer: accepts full-line write bursts, acknowledges
// them as soon as the line is captured, and drains lines to memory in FIFO
// order. Reads to a line still in the buffer are held until it is written.
//
//   state  | meaning
//   F_IDLE | waiting for an eviction AW (accepted when not full)
//   F_DATA | capturing the line's W beats into the tail entry
//   F_RESP | returning the early B response to L2
//   D_IDLE | waiting for the head entry to be committed
//   D_AW   | issuing the head line's address downstream
//   D_W    | streaming the head line's beats downstream
//   D_B    | waiting for the downstream response, then freeing the head
module l2_writeback_buffer #(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 64,
  parameter int                   ID_WIDTH   = 3,
  parameter int                   DEPTH      = 4,
  parameter int                   BEATS      = 8,
  parameter logic [ID_WIDTH-1:0]  WB_ID      = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  l2_writeback_buffer_if.slave       s,
  l2_writeback_buffer_if.master      m,
  output logic                       wb_err,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int OFF_W  = $clog2(BEATS * DATA_WIDTH / 8);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OCC_W  = PTR_W + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_RESP} fill_state_t;
  typedef enum logic [1:0] {D_IDLE, D_AW, D_W, D_B} drain_state_t;

  fill_state_t  fill_state, fill_next;
  drain_state_t drain_state, drain_next;

  logic [DEPTH-1:0]    ent_valid;
  logic [DEPTH-1:0]    ent_commit;
  logic [TAG_W-1:0]    ent_tag  [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH*BEATS];
  logic [STRB_W-1:0]   ent_strb [DEPTH*BEATS];

  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    fill_cnt, drain_cnt;
  logic [ID_WIDTH-1:0] fill_id;

  logic aw_fire, w_fire, maw_fire, mw_fire, mb_fire;
  logic fill_last, drain_last, full, hit;
  logic unused;

  assign aw_fire    = s.aw_valid && s.aw_ready;
  assign w_fire     = s.w_valid && s.w_ready;
  assign maw_fire   = m.aw_valid && m.aw_ready;
  assign mw_fire    = m.w_valid && m.w_ready;
  assign mb_fire    = m.b_valid && m.b_ready;
  assign fill_last  = fill_cnt == CNT_W'(BEATS - 1);
  assign drain_last = drain_cnt == CNT_W'(BEATS - 1);
  assign full       = occupancy == OCC_W'(DEPTH);

  // Upstream fill sequencing and its handshake outputs.
  always_comb begin
    fill_next  = fill_state;
    s.aw_ready = 1'b0;
    s.w_ready  = 1'b0;
    s.b_valid  = 1'b0;
    case (fill_state)
      F_IDLE: begin
        s.aw_ready = !full;
        if (s.aw_valid && !full) fill_next = F_DATA;
      end
      F_DATA: begin
        s.w_ready = 1'b1;
        if (s.w_valid && fill_last) fill_next = F_RESP;
      end
      F_RESP: begin
        s.b_valid = 1'b1;
        if (s.b_ready) fill_next = F_IDLE;
      end
      default: fill_next = F_IDLE;
    endcase
  end

  assign s.b_id   = fill_id;
  assign s.b_resp = 2'b00;

  // Downstream drain sequencing and its handshake outputs.
  always_comb begin
    drain_next = drain_state;
    m.aw_valid = 1'b0;
    m.w_valid  = 1'b0;
    m.b_ready  = 1'b0;
    case (drain_state)
      D_IDLE: if (ent_commit[head]) drain_next = D_AW;
      D_AW: begin
        m.aw_valid = 1'b1;
        if (m.aw_ready) drain_next = D_W;
      end
      D_W: begin
        m.w_valid = 1'b1;
        if (m.w_ready && drain_last) drain_next = D_B;
      end
      D_B: begin
        m.b_ready = 1'b1;
        if (m.b_valid) drain_next = D_IDLE;
      end
      default: drain_next = D_IDLE;
    endcase
  end

  // Head and beat counter only move on handshakes, so payload holds while stalled.
  assign m.aw_addr = {ent_tag[head], OFF_W'(0)};
  assign m.aw_id   = WB_ID;
  assign m.aw_len  = 8'(BEATS - 1);
  assign m.w_data  = ent_data[{head, drain_cnt}];
  assign m.w_strb  = ent_strb[{head, drain_cnt}];
  assign m.w_last  = drain_last;

  // A read hits if its line is allocated anywhere, including the line being filled.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_tag[i] == s.ar_addr[ADDR_WIDTH-1:OFF_W]) hit = 1'b1;
    end
  end

  assign m.ar_valid = s.ar_valid && !hit;
  assign s.ar_ready = m.ar_ready && !hit;
  assign m.ar_addr  = s.ar_addr;
  assign m.ar_id    = s.ar_id;
  assign m.ar_len   = s.ar_len;
  assign s.r_valid  = m.r_valid;
  assign s.r_data   = m.r_data;
  assign s.r_id     = m.r_id;
  assign s.r_resp   = m.r_resp;
  assign s.r_last   = m.r_last;
  assign m.r_ready  = s.r_ready;

  assign unused = ^{s.aw_len, s.w_last, s.aw_addr[OFF_W-1:0], m.b_id};

  // Control state: FSMs, pointers, entry flags, occupancy and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state  <= F_IDLE;
      drain_state <= D_IDLE;
      ent_valid   <= '0;
      ent_commit  <= '0;
      head        <= '0;
      tail        <= '0;
      fill_cnt    <= '0;
      drain_cnt   <= '0;
      fill_id     <= '0;
      occupancy   <= '0;
      wb_err      <= 1'b0;
    end else begin
      fill_state  <= fill_next;
      drain_state <= drain_next;
      if (aw_fire) begin
        ent_valid[tail] <= 1'b1;
        fill_id         <= s.aw_id;
      end
      if (w_fire) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
        if (fill_last) begin
          ent_commit[tail] <= 1'b1;
          tail             <= tail + PTR_W'(1);
        end
      end
      if (mw_fire) drain_cnt <= drain_cnt + CNT_W'(1);
      if (mb_fire) begin
        ent_valid[head]  <= 1'b0;
        ent_commit[head] <= 1'b0;
        head             <= head + PTR_W'(1);
        wb_err           <= wb_err | (m.b_resp != 2'b00);
      end
      if (aw_fire && !mb_fire)      occupancy <= occupancy + OCC_W'(1);
      else if (!aw_fire && mb_fire) occupancy <= occupancy - OCC_W'(1);
    end
  end

  // Line storage needs no reset; entries are only read once marked valid.
  always_ff @(posedge clk) begin
    if (aw_fire) ent_tag[tail] <= s.aw_addr[ADDR_WIDTH-1:OFF_W];
    if (w_fire) begin
      ent_data[{tail, fill_cnt}] <= s.w_data;
      ent_strb[{tail, fill_cnt}] <= s.w_strb;
    end
  end

  // maw_fire is implied by the D_AW transition; kept for readability of intent.
  logic unused_maw;
  assign unused_maw = maw_fire;
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Bench for l2_writeback_buffer: a line-level queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_l2_writeback_buffer;
  localparam int AW = 32, DW = 64, IW = 3, DEPTH = 4, BEATS = 8, TMO = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_writeback_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s_if ();
  l2_writeback_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_if ();
  logic       wb_err;
  logic [2:0] occupancy;

  l2_writeback_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                        .DEPTH(DEPTH), .BEATS(BEATS), .WB_ID(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if),
    .wb_err(wb_err), .occupancy(occupancy));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] bdata(input int base, input int b);
    return {32'(base), 32'(b) * 32'h1111_1111};
  endfunction
  function automatic logic [7:0] bstrb(input int b);
    return 8'(8'hFF >> b);
  endfunction

  // ---------------- line-level model ----------------
  typedef struct {
    logic [25:0]  line;
    logic [511:0] data;
    logic [63:0]  strb;
    int           nbeats;
  } line_t;

  line_t          mq[$];
  int             fill_beat = -1;
  bit             resp_pend = 0;
  logic [2:0]     resp_id = '0;
  bit             model_err = 0;
  int             dw_beat = 0;
  logic [31:0]    aw_log[$];
  int             w_beats = 0;
  int             last_at = 0;

  function automatic bit buffered(input logic [31:0] a);
    foreach (mq[i]) if (mq[i].line == a[31:6]) return 1'b1;
    return 1'b0;
  endfunction

  // Compare DUT against the model each cycle, then apply this cycle's handshakes.
  always @(negedge clk) begin : cmp
    bit    hit;
    line_t tmp;
    if (!rst_n) begin
      mq.delete();
      fill_beat = -1;
      resp_pend = 0;
      model_err = 0;
      dw_beat   = 0;
    end else begin
      hit = buffered(s_if.ar_addr);
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("wb_err", 64'(wb_err), 64'(model_err));
      chk("s_aw_ready", 64'(s_if.aw_ready), 64'(fill_beat < 0 && !resp_pend && mq.size() < DEPTH));
      chk("s_w_ready", 64'(s_if.w_ready), 64'(fill_beat >= 0));
      chk("s_b_valid", 64'(s_if.b_valid), 64'(resp_pend));
      if (resp_pend) chk("s_b_id", 64'(s_if.b_id), 64'(resp_id));
      chk("m_ar_valid", 64'(m_if.ar_valid), 64'(s_if.ar_valid && !hit));
      chk("s_ar_ready", 64'(s_if.ar_ready), 64'(m_if.ar_ready && !hit));
      if (m_if.ar_valid) chk("m_ar_addr", 64'(m_if.ar_addr), 64'(s_if.ar_addr));
      chk("s_r_valid", 64'(s_if.r_valid), 64'(m_if.r_valid));
      if (m_if.r_valid) chk("s_r_data", s_if.r_data, m_if.r_data);

      if (m_if.aw_valid && m_if.aw_ready) begin
        chk("m_aw_committed", 64'(mq.size() > 0 && mq[0].nbeats == BEATS), 64'd1);
        if (mq.size() > 0) chk("m_aw_addr", 64'(m_if.aw_addr), 64'({mq[0].line, 6'b0}));
        chk("m_aw_len", 64'(m_if.aw_len), 64'd7);
        chk("m_aw_id", 64'(m_if.aw_id), 64'd0);
        aw_log.push_back(m_if.aw_addr);
      end
      if (m_if.w_valid && m_if.w_ready) begin
        if (mq.size() > 0) begin
          chk("m_w_data", m_if.w_data, mq[0].data[dw_beat*64 +: 64]);
          chk("m_w_strb", 64'(m_if.w_strb), 64'(mq[0].strb[dw_beat*8 +: 8]));
        end
        chk("m_w_last", 64'(m_if.w_last), 64'(dw_beat == BEATS - 1));
        w_beats++;
        if (m_if.w_last) last_at = w_beats;
        dw_beat = (dw_beat + 1) % BEATS;
      end

      if (s_if.w_valid && s_if.w_ready && fill_beat >= 0 && mq.size() > 0) begin
        tmp = mq[mq.size()-1];
        tmp.data[fill_beat*64 +: 64] = s_if.w_data;
        tmp.strb[fill_beat*8 +: 8]   = s_if.w_strb;
        tmp.nbeats++;
        mq[mq.size()-1] = tmp;
        fill_beat++;
        if (fill_beat == BEATS) begin
          fill_beat = -1;
          resp_pend = 1;
        end
      end
      if (s_if.b_valid && s_if.b_ready) resp_pend = 0;
      if (m_if.b_valid && m_if.b_ready && mq.size() > 0) begin
        model_err = model_err | (m_if.b_resp != 2'b00);
        void'(mq.pop_front());
      end
      if (s_if.aw_valid && s_if.aw_ready) begin
        tmp.line   = s_if.aw_addr[31:6];
        tmp.data   = '0;
        tmp.strb   = '0;
        tmp.nbeats = 0;
        mq.push_back(tmp);
        fill_beat = 0;
        resp_id   = s_if.aw_id;
      end
    end
  end

  // ---------------- downstream memory responder ----------------
  int         b_pend = 0;
  logic [1:0] resp_cfg = 2'b00;
  always @(negedge clk) begin
    if (!rst_n) b_pend = 0;
    else begin
      if (m_if.w_valid && m_if.w_ready && m_if.w_last) b_pend++;
      if (m_if.b_valid && m_if.b_ready) b_pend--;
    end
  end
  always @(posedge clk) begin
    #1;
    m_if.b_valid = (b_pend > 0) && rst_n;
    m_if.b_resp  = resp_cfg;
    m_if.b_id    = 3'd0;
  end

  // ---------------- upstream stimulus ----------------
  task automatic send_line(input logic [31:0] addr, input logic [2:0] id, input int base,
                           output int lat);
    int n;
    int t0;
    @(posedge clk); #1;
    s_if.aw_valid = 1'b1;
    s_if.aw_addr  = addr;
    s_if.aw_id    = id;
    n = 0;
    @(negedge clk);
    while (!s_if.aw_ready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) chk("aw_accept_timeout", 64'(n), 64'(TMO - 1));
    t0 = cyc;
    for (int b = 0; b < BEATS; b++) begin
      @(posedge clk); #1;
      s_if.aw_valid = 1'b0;
      s_if.w_valid  = 1'b1;
      s_if.w_data   = bdata(base, b);
      s_if.w_strb   = bstrb(b);
      s_if.w_last   = (b == BEATS - 1);
      n = 0;
      @(negedge clk);
      while (!s_if.w_ready && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) chk("w_accept_timeout", 64'(n), 64'(TMO - 1));
    end
    @(posedge clk); #1;
    s_if.w_valid = 1'b0;
    s_if.w_last  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_if.b_valid && n < TMO) begin @(negedge clk); n++; end
    chk("s_b_seen", 64'(s_if.b_valid), 64'd1);
    chk("s_b_id_task", 64'(s_if.b_id), 64'(id));
    lat = cyc - t0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    @(negedge clk);
    while (occupancy != 0 && n < TMO) begin @(negedge clk); n++; end
    chk(name, 64'(occupancy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [31:0] exp_order [5];
    s_if.aw_valid = 0; s_if.aw_addr = '0; s_if.aw_id = '0; s_if.aw_len = 8'd7;
    s_if.w_valid = 0; s_if.w_data = '0; s_if.w_strb = '0; s_if.w_last = 0;
    s_if.b_ready = 1; s_if.ar_valid = 0; s_if.ar_addr = '0; s_if.ar_id = '0;
    s_if.ar_len = 8'd7; s_if.r_ready = 1;
    m_if.aw_ready = 1; m_if.w_ready = 1; m_if.ar_ready = 1;
    m_if.r_valid = 0; m_if.r_data = '0; m_if.r_id = '0; m_if.r_resp = '0; m_if.r_last = 0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_s_aw_ready", 64'(s_if.aw_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_wb_err", 64'(wb_err), 64'd0);
    chk("rst_m_aw_valid", 64'(m_if.aw_valid), 64'd0);
    chk("rst_m_w_valid", 64'(m_if.w_valid), 64'd0);
    chk("rst_s_b_valid", 64'(s_if.b_valid), 64'd0);

    // single eviction
    send_line(32'h8000_0040, 3'd5, 1, lat);
    chk("b_latency", 64'(lat), 64'd9);
    chk("occ_single", 64'(occupancy), 64'd1);
    wait_empty("single_drained");
    chk("single_aw_count", 64'(aw_log.size()), 64'd1);
    if (aw_log.size() > 0) chk("single_m_aw_addr", 64'(aw_log[0]), 64'h8000_0040);
    chk("single_w_beats", 64'(w_beats), 64'd8);
    chk("single_last_at", 64'(last_at), 64'd8);

    // four evictions with downstream AW stalled
    @(posedge clk); #1;
    m_if.aw_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_line(32'h8000_0040 + 32'(i * 'h40), 3'(i), 10 + i, lat);
    @(negedge clk);
    chk("full_occupancy", 64'(occupancy), 64'd4);
    chk("full_s_aw_ready", 64'(s_if.aw_ready), 64'd0);

    // non-buffered read while full: forwarded combinationally, R passes through
    @(posedge clk); #1;
    s_if.ar_valid = 1'b1; s_if.ar_addr = 32'h9000_0000; s_if.ar_id = 3'd2;
    m_if.r_valid = 1'b1; m_if.r_data = 64'hDEAD_BEEF_0123_4567; m_if.r_id = 3'd2; m_if.r_last = 1'b1;
    @(negedge clk);
    chk("miss_m_ar_valid", 64'(m_if.ar_valid), 64'd1);
    chk("miss_s_ar_ready", 64'(s_if.ar_ready), 64'd1);
    chk("r_data_pass", s_if.r_data, 64'hDEAD_BEEF_0123_4567);
    chk("r_last_pass", 64'(s_if.r_last), 64'd1);

    // read hitting buffered line 0x8000_0040
    @(posedge clk); #1;
    m_if.r_valid = 1'b0;
    s_if.ar_addr = 32'h8000_0048;
    @(negedge clk);
    chk("hit_m_ar_valid", 64'(m_if.ar_valid), 64'd0);
    chk("hit_s_ar_ready", 64'(s_if.ar_ready), 64'd0);

    fork
      send_line(32'h8000_0200, 3'd6, 20, lat);
      begin
        int n;
        repeat (3) begin
          @(negedge clk);
          chk("stall_s_aw_ready", 64'(s_if.aw_ready), 64'd0);
        end
        @(posedge clk); #1;
        m_if.aw_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(m_if.b_valid && m_if.b_ready) && n < TMO) begin @(negedge clk); n++; end
        chk("hit_hold_at_b", 64'(m_if.ar_valid), 64'd0);
        @(negedge clk);
        chk("hit_release", 64'(m_if.ar_valid), 64'd1);
        @(posedge clk); #1;
        s_if.ar_valid = 1'b0;
      end
    join
    wait_empty("fifo_drained");
    exp_order[0] = 32'h8000_0040; exp_order[1] = 32'h8000_0080;
    exp_order[2] = 32'h8000_00C0; exp_order[3] = 32'h8000_0100;
    exp_order[4] = 32'h8000_0200;
    chk("fifo_aw_count", 64'(aw_log.size()), 64'd6);
    for (int i = 0; i < 5; i++)
      if (aw_log.size() > i + 1) chk("fifo_order", 64'(aw_log[i+1]), 64'(exp_order[i]));

    // downstream error is sticky
    resp_cfg = 2'b10;
    send_line(32'h8000_0400, 3'd1, 30, lat);
    wait_empty("err_drained");
    chk("wb_err_set", 64'(wb_err), 64'd1);
    resp_cfg = 2'b00;
    send_line(32'h8000_0440, 3'd3, 31, lat);
    wait_empty("ok_drained");
    chk("wb_err_sticky", 64'(wb_err), 64'd1);

    // reset during beat 3 of a fill
    @(posedge clk); #1;
    s_if.aw_valid = 1'b1; s_if.aw_addr = 32'h8000_0800; s_if.aw_id = 3'd4;
    @(posedge clk); #1;
    s_if.aw_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_if.w_valid = 1'b1; s_if.w_data = bdata(99, b); s_if.w_strb = 8'hFF;
      @(posedge clk); #1;
    end
    s_if.w_data = bdata(99, 3);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_occupancy", 64'(occupancy), 64'd0);
    chk("rst_mid_s_b_valid", 64'(s_if.b_valid), 64'd0);
    chk("rst_mid_m_aw_valid", 64'(m_if.aw_valid), 64'd0);
    chk("rst_mid_m_w_valid", 64'(m_if.w_valid), 64'd0);
    chk("rst_mid_wb_err", 64'(wb_err), 64'd0);
    s_if.w_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_line(32'h8000_0800, 3'd4, 40, lat);
    chk("post_rst_latency", 64'(lat), 64'd9);
    wait_empty("post_rst_drained");
    if (aw_log.size() > 0) chk("post_rst_aw_addr", 64'(aw_log[aw_log.size()-1]), 64'h8000_0800);
    chk("post_rst_aw_count", 64'(aw_log.size()), 64'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
